// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press, short, long, repeat and
// double-press events, all registered and timed in c50M cycles.
module button_event_decoder #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int DOUBLE_CYCLES = 15_000_000,
    parameter int CNT_W         = 26
) (
    input  logic c50M,
    input  logic Reset,
    input  logic ButtonIn,
    output logic Held,
    output logic PressPulse,
    output logic ShortPress,
    output logic LongPress,
    output logic RepeatPulse,
    output logic DoublePress
);

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONGH,
        WAIT2,
        DBLH
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             btn_q;
    logic             rise, fall, clr;
    logic             press_nxt, short_nxt, long_nxt, repeat_nxt, double_nxt;

    assign rise = ButtonIn & ~btn_q;
    assign fall = ~ButtonIn & btn_q;

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        clr        = 1'b0;
        press_nxt  = 1'b0;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
        double_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    clr       = 1'b1;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                // A release on the long-press cycle wins over the long press.
                if (fall) begin
                    state_nxt = WAIT2;
                    clr       = 1'b1;
                    short_nxt = 1'b1;
                end else if (ButtonIn && cnt == LONG_LAST) begin
                    state_nxt = LONGH;
                    clr       = 1'b1;
                    long_nxt  = 1'b1;
                end
            end
            LONGH: begin
                if (fall) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (cnt == REPEAT_LAST) begin
                    clr        = 1'b1;
                    repeat_nxt = 1'b1;
                end
            end
            WAIT2: begin
                // Timeout is tested first so a rise on the timeout cycle is dropped.
                if (cnt == DOUBLE_LAST) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end else if (rise) begin
                    state_nxt  = DBLH;
                    clr        = 1'b1;
                    press_nxt  = 1'b1;
                    double_nxt = 1'b1;
                end
            end
            DBLH: begin
                if (fall) begin
                    state_nxt = IDLE;
                    clr       = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                clr       = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (clr)
            cnt_nxt = '0;
        else if (&cnt)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; btn_q resets to 1 so a button held through reset is ignored.
    always_ff @(posedge c50M or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_q       <= 1'b1;
            Held        <= 1'b0;
            PressPulse  <= 1'b0;
            ShortPress  <= 1'b0;
            LongPress   <= 1'b0;
            RepeatPulse <= 1'b0;
            DoublePress <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_q       <= ButtonIn;
            Held        <= ButtonIn;
            PressPulse  <= press_nxt;
            ShortPress  <= short_nxt;
            LongPress   <= long_nxt;
            RepeatPulse <= repeat_nxt;
            DoublePress <= double_nxt;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: a timestamp-based event model checked every cycle, plus
// directed scenarios whose pulse cycles are pinned to hand-computed values.
module tb_button_event_decoder;

    localparam int LONG   = 8;
    localparam int REPEAT = 3;
    localparam int DOUBLE = 5;

    logic c50M = 1'b0;
    logic Reset;
    logic ButtonIn;
    logic Held, PressPulse, ShortPress, LongPress, RepeatPulse, DoublePress;

    button_event_decoder #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT),
        .DOUBLE_CYCLES(DOUBLE),
        .CNT_W        (4)
    ) dut (
        .c50M       (c50M),
        .Reset      (Reset),
        .ButtonIn   (ButtonIn),
        .Held       (Held),
        .PressPulse (PressPulse),
        .ShortPress (ShortPress),
        .LongPress  (LongPress),
        .RepeatPulse(RepeatPulse),
        .DoublePress(DoublePress)
    );

    always #5 c50M = ~c50M;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Event model: remembers when the current press, long press and short press
    // happened and derives each pulse from elapsed cycle counts.
    int   cyc        = 0;
    int   held_since = -1;
    int   long_edge  = -1;
    int   short_edge = -1;
    bit   dbl        = 1'b0;
    bit   prev_b     = 1'b1;
    logic [5:0] exp_out = '0;  // {held, press, short, long, repeat, double}

    always @(posedge c50M or posedge Reset) begin
        bit b;
        if (Reset) begin
            held_since = -1;
            long_edge  = -1;
            short_edge = -1;
            dbl        = 1'b0;
            prev_b     = 1'b1;
            exp_out    = '0;
        end else begin
            cyc++;
            b       = ButtonIn;
            exp_out = {b, 5'b0};
            if (b && !prev_b) begin
                if (short_edge >= 0 && cyc - short_edge < DOUBLE) begin
                    exp_out[4] = 1'b1;
                    exp_out[0] = 1'b1;
                    held_since = cyc;
                    dbl        = 1'b1;
                end else if (!(short_edge >= 0 && cyc - short_edge == DOUBLE)) begin
                    exp_out[4] = 1'b1;
                    held_since = cyc;
                    dbl        = 1'b0;
                end
                long_edge  = -1;
                short_edge = -1;
            end else if (b && prev_b) begin
                if (held_since >= 0 && !dbl) begin
                    if (long_edge < 0 && cyc - held_since == LONG) begin
                        exp_out[2] = 1'b1;
                        long_edge  = cyc;
                    end else if (long_edge >= 0 && (cyc - long_edge) % REPEAT == 0) begin
                        exp_out[1] = 1'b1;
                    end
                end
            end else if (!b && prev_b) begin
                if (held_since >= 0 && !dbl && long_edge < 0) begin
                    exp_out[3] = 1'b1;
                    short_edge = cyc;
                end
                held_since = -1;
                long_edge  = -1;
                dbl        = 1'b0;
            end
            if (short_edge >= 0 && cyc - short_edge >= DOUBLE)
                short_edge = -1;
            prev_b = b;
        end
    end

    always begin
        @(posedge c50M);
        #2;
        check("outputs{held,press,short,long,repeat,double}",
              {Held, PressPulse, ShortPress, LongPress, RepeatPulse, DoublePress}, exp_out);
    end

    // Pulse log used to pin the model with literal cycle numbers.
    int n_press = 0, n_short = 0, n_long = 0, n_rep = 0, n_dbl = 0;
    int last_press = -1, last_short = -1, last_long = -1, last_rep = -1, last_dbl = -1;

    always @(negedge c50M) begin
        if (PressPulse)  begin n_press++; last_press = cyc; end
        if (ShortPress)  begin n_short++; last_short = cyc; end
        if (LongPress)   begin n_long++;  last_long  = cyc; end
        if (RepeatPulse) begin n_rep++;   last_rep   = cyc; end
        if (DoublePress) begin n_dbl++;   last_dbl   = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge c50M);
    endtask

    task automatic settle();
        ButtonIn = 1'b0;
        tick(10);
    endtask

    int t, b_press, b_short, b_long, b_rep, b_dbl;

    task automatic mark();
        t       = cyc;
        b_press = n_press;
        b_short = n_short;
        b_long  = n_long;
        b_rep   = n_rep;
        b_dbl   = n_dbl;
    endtask

    initial begin
        Reset    = 1'b1;
        ButtonIn = 1'b0;
        tick(2);
        check("reset_outputs",
              {Held, PressPulse, ShortPress, LongPress, RepeatPulse, DoublePress}, 0);
        Reset = 1'b0;
        settle();

        // Short press
        mark();
        ButtonIn = 1'b1; tick(4);
        ButtonIn = 1'b0; tick(8);
        check("t1_press_cycle", last_press, t + 1);
        check("t1_short_cycle", last_short, t + 5);
        check("t1_no_long", n_long - b_long, 0);
        settle();

        // Long hold with auto-repeat
        mark();
        ButtonIn = 1'b1; tick(21);
        ButtonIn = 1'b0; tick(8);
        check("t2_press_cycle", last_press, t + 1);
        check("t2_long_cycle", last_long, t + 9);
        check("t2_repeat_count", n_rep - b_rep, 4);
        check("t2_last_repeat", last_rep, t + 21);
        check("t2_no_short", n_short - b_short, 0);
        settle();

        // Double press
        mark();
        ButtonIn = 1'b1; tick(2);
        ButtonIn = 1'b0; tick(2);
        ButtonIn = 1'b1; tick(3);
        ButtonIn = 1'b0; tick(8);
        check("t3_short_cycle", last_short, t + 3);
        check("t3_double_cycle", last_dbl, t + 5);
        check("t3_press_with_double", last_press, t + 5);
        check("t3_single_short", n_short - b_short, 1);
        settle();

        // Double press on the last cycle of the window
        mark();
        ButtonIn = 1'b1; tick(2);
        ButtonIn = 1'b0; tick(4);
        ButtonIn = 1'b1; tick(2);
        check("t3b_late_double", last_dbl, t + 7);
        settle();

        // Window expires, then a normal press
        mark();
        ButtonIn = 1'b1; tick(2);
        ButtonIn = 1'b0; tick(6);
        ButtonIn = 1'b1; tick(2);
        check("t4_press_cycle", last_press, t + 9);
        check("t4_no_double", n_dbl - b_dbl, 0);
        settle();

        // Rise exactly on the timeout cycle is dropped
        mark();
        ButtonIn = 1'b1; tick(2);
        ButtonIn = 1'b0; tick(5);
        ButtonIn = 1'b1; tick(3);
        check("t4b_timeout_rise_dropped", n_press - b_press, 1);
        ButtonIn = 1'b0; tick(1);
        ButtonIn = 1'b1; tick(2);
        check("t4b_next_press", last_press, t + 12);
        check("t4b_no_double", n_dbl - b_dbl, 0);
        settle();

        // Release on the cycle LongPress would fire
        mark();
        ButtonIn = 1'b1; tick(8);
        ButtonIn = 1'b0; tick(3);
        check("t7_short_on_long_cycle", last_short, t + 9);
        check("t7_no_long", n_long - b_long, 0);
        settle();

        // Button held across reset
        ButtonIn = 1'b1; tick(2);
        Reset = 1'b1; tick(2);
        Reset = 1'b0;
        mark();
        tick(6);
        check("t5_no_press_after_reset", n_press - b_press, 0);
        ButtonIn = 1'b0; tick(2);
        mark();
        ButtonIn = 1'b1; tick(2);
        check("t5_repress_cycle", last_press, t + 1);
        settle();

        // Reset mid-press
        mark();
        ButtonIn = 1'b1; tick(3);
        check("t6_held_before_reset", Held, 1);
        Reset = 1'b1;
        #1;
        check("t6_outputs_async_clear",
              {Held, PressPulse, ShortPress, LongPress, RepeatPulse, DoublePress}, 0);
        tick(1);
        Reset = 1'b0;
        mark();
        tick(10);
        check("t6_no_events_after_reset", (n_press - b_press) + (n_long - b_long), 0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
